// File: rtl/seq_divider_pkg.sv
// Shared types and default sizing for the sequential restoring divider.
package div_pkg;
    localparam int WIDTH_D_DEF = 16;
    localparam int WIDTH_C_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider_if
    import div_pkg::*;
    #(parameter int WIDTH_D = WIDTH_D_DEF);

    logic               start;
    logic [WIDTH_D-1:0] dividend;
    logic [WIDTH_D-1:0] divisor;
    logic               busy;
    logic               done;
    logic [WIDTH_D-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_datapath.sv
// Restoring-division datapath: partial remainder, quotient shifter and divisor register.
module seq_div_datapath
    import div_pkg::*;
    #(parameter int WIDTH_D = WIDTH_D_DEF)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               shift,
    input  logic               sub,
    input  logic [WIDTH_D-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic [WIDTH_D-1:0] quo_res,
    output logic [WIDTH_D-1:0] rem_res
);

    // rem carries one extra bit: after the shift it can reach 2*divisor-1,
    // which overflows WIDTH_D bits when the divisor has its MSB set.
    logic [WIDTH_D:0]   rem;
    logic [WIDTH_D-1:0] quo;
    logic [WIDTH_D-1:0] dsr;
    logic [WIDTH_D+1:0] diff;
    logic               borrow;
    logic [WIDTH_D:0]   rem_sub;
    logic [WIDTH_D-1:0] quo_sub;

    assign diff    = {1'b0, rem} - {2'b00, dsr};
    assign borrow  = diff[WIDTH_D+1];
    assign rem_sub = borrow ? rem : diff[WIDTH_D:0];
    assign quo_sub = {quo[WIDTH_D-1:1], ~borrow};

    // Values the registers take at the end of the current SUB step.
    assign quo_res = quo_sub;
    assign rem_res = rem_sub[WIDTH_D-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
        end else if (shift) begin
            {rem, quo} <= {rem[WIDTH_D-1:0], quo, 1'b0};
        end else if (sub) begin
            rem <= rem_sub;
            quo <= quo_sub;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: FSM, iteration counter and result registers.
//   state | meaning
//   IDLE  | waiting for start; divisor==0 resolves here in one edge
//   SHIFT | shift {rem,quo} left, count one iteration
//   SUB   | trial subtract, restore on borrow
//   DONE  | one-cycle completion pulse
module seq_divider
    import div_pkg::*;
    #(
        parameter int WIDTH_D = WIDTH_D_DEF,
        parameter int WIDTH_C = WIDTH_C_DEF
    )
(
    input  logic         clk,
    input  logic         reset_n,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH_C-1:0] LAST = WIDTH_C'(WIDTH_D);

    state_t             state;
    state_t             state_next;
    logic [WIDTH_C-1:0] count;
    logic               load;
    logic               shift;
    logic               sub;
    logic               finish;
    logic               zero_div;
    logic [WIDTH_D-1:0] quo_res;
    logic [WIDTH_D-1:0] rem_res;
    logic [WIDTH_D-1:0] quotient_q;
    logic [WIDTH_D-1:0] remainder_q;
    logic               div_by_zero_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        sub        = 1'b0;
        finish     = 1'b0;
        zero_div   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        zero_div   = 1'b1;
                        state_next = DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift      = 1'b1;
                state_next = SUB;
            end
            SUB: begin
                sub = 1'b1;
                if (count < LAST) begin
                    state_next = SHIFT;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift) begin
            count <= count + WIDTH_C'(1);
        end
    end

    // Results are taken from the final SUB step so they are valid while done is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (zero_div) begin
            quotient_q    <= '1;
            remainder_q   <= bus.dividend;
            div_by_zero_q <= 1'b1;
        end else if (finish) begin
            quotient_q    <= quo_res;
            remainder_q   <= rem_res;
            div_by_zero_q <= 1'b0;
        end else if (load) begin
            div_by_zero_q <= 1'b0;
        end
    end

    seq_div_datapath #(.WIDTH_D(WIDTH_D)) u_datapath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .shift    (shift),
        .sub      (sub),
        .dividend (bus.dividend),
        .divisor  (bus.divisor),
        .quo_res  (quo_res),
        .rem_res  (rem_res)
    );

    assign bus.busy        = (state == SHIFT) || (state == SUB);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH_D(W)) bus ();

    seq_divider #(.WIDTH_D(W), .WIDTH_C(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called at a negedge with the divider idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit keep, input bit disturb, input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        logic [W-1:0] prev_q, prev_r;
        int           n, busy_n;
        bit           hold_bad;
        model(a, b, eq, er, ez);
        prev_q = bus.quotient;
        prev_r = bus.remainder;
        hold_bad = 1'b0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        n = 0;
        busy_n = 0;
        @(negedge clk);
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            if (bus.quotient !== prev_q || bus.remainder !== prev_r) hold_bad = 1'b1;
            if (disturb) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.dividend = 16'($urandom);
                bus.divisor  = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check({tag, " done_latency"}, n, (b == 0) ? 32'd0 : 32'd32);
        check({tag, " busy_cycles"}, busy_n, (b == 0) ? 32'd0 : 32'd32);
        check({tag, " no_intermediate"}, {31'd0, hold_bad}, 32'd0);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_by_zero"}, bus.div_by_zero, ez);
        if (disturb) bus.start = 1'b1;
        @(negedge clk);
        if (!keep) bus.start = 1'b0;
        check({tag, " done_one_cycle"}, bus.done, 1'b0);
        check({tag, " idle_not_busy"}, bus.busy, 1'b0);
        check({tag, " quotient_hold"}, bus.quotient, eq);
        check({tag, " remainder_hold"}, bus.remainder, er);
    endtask

    initial begin
        int done_seen;
        logic [W-1:0] ra, rb;
        int sel;
        bit keep;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        check("reset quotient", bus.quotient, 0);
        check("reset remainder", bus.remainder, 0);
        check("reset div_by_zero", bus.div_by_zero, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(16'd100, 16'd7, 1'b0, 1'b0, "basic_100_7");
        run_op(16'hFFFF, 16'd1, 1'b0, 1'b0, "ffff_by_1");
        run_op(16'd3, 16'd10, 1'b0, 1'b0, "3_by_10");
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "ffff_by_ffff");
        run_op(16'd5, 16'd0, 1'b0, 1'b0, "5_by_0");
        run_op(16'd9, 16'd3, 1'b0, 1'b0, "9_by_3_after_zero");
        run_op(16'd100, 16'd7, 1'b0, 1'b1, "ignored_start");

        // Reset at E+10 of an in-flight 100 / 7.
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset quotient", bus.quotient, 0);
        check("midreset remainder", bus.remainder, 0);
        check("midreset div_by_zero", bus.div_by_zero, 0);
        check("midreset busy", bus.busy, 0);
        check("midreset done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("midreset no_done", done_seen, 0);
        run_op(16'd50, 16'd8, 1'b0, 1'b0, "50_by_8_after_reset");

        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      rb = '0;
            else if (sel < 4)  rb = 16'($urandom_range(1, 15));
            else if (sel == 4) rb = 16'hFFFF - 16'($urandom_range(0, 3));
            else               rb = 16'($urandom);
            keep = 1'($urandom_range(0, 1));
            run_op(ra, rb, keep, 1'b0, "random");
        end
        bus.start = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
